// File: rtl/pp_frame_sequencer_if.sv
// AXI-Stream style handshake bundle used for the sequencer's input and both outputs.
// The master drives data/valid and the slave answers with ready.
interface pp_frame_sequencer_if #(
    parameter int DW = 128
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/pp_frame_sequencer.sv
// Frame-level sequencer for a ping-pong output pair.
// Each frame is framed by header beats broadcast to both outputs. The payload is passed
// straight through and switches between out1 and out2 every PP_GROUP*PACKET_SIZE beats.
// Metadata beats, also broadcast, close the frame. All counters move only on handshakes.
module pp_frame_sequencer #(
    parameter int DW          = 128,
    parameter int PP_GROUP    = 2,
    parameter int PACKET_SIZE = 2,
    parameter int FRAME_SIZE  = 256,
    parameter int HEADER_LEN  = 2,
    parameter int META_LEN    = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    output logic                        busy,
    output logic                        path,
    output logic [15:0]                 frame_cnt,
    output logic [15:0]                 counter_fs,
    pp_frame_sequencer_if.slave         axis_in,
    pp_frame_sequencer_if.master        axis_out1,
    pp_frame_sequencer_if.master        axis_out2
);

    localparam int G  = PP_GROUP * PACKET_SIZE;
    localparam int GW = (G > 1) ? $clog2(G) : 1;

    localparam logic [7:0]    HDR_LAST  = 8'(HEADER_LEN - 1);
    localparam logic [7:0]    META_LAST = 8'(META_LEN - 1);
    localparam logic [15:0]   FS_LAST   = 16'(FRAME_SIZE - 1);
    localparam logic [GW-1:0] G_LAST    = GW'(G - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEADER  = 2'd1,
        S_PAYLOAD = 2'd2,
        S_META    = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [7:0]    k_r, k_s;
    logic [GW-1:0] g_r, g_s;
    logic          taken1_r, taken1_s;
    logic          taken2_r, taken2_s;
    logic          path_r, path_s;
    logic [15:0]   frame_cnt_r, frame_cnt_s;
    logic [15:0]   counter_fs_r, counter_fs_s;

    logic [DW-1:0] bcast_s;
    logic          hs1_s;
    logic          hs2_s;
    logic          in_hs_s;
    logic          beat_done_s;

    assign busy       = (state_r != S_IDLE);
    assign path       = path_r;
    assign frame_cnt  = frame_cnt_r;
    assign counter_fs = counter_fs_r;

    // Build the broadcast word for the current header or metadata beat
    always_comb begin
        bcast_s = {DW{1'b0}};
        if (state_r == S_HEADER) begin
            bcast_s[47:0] = {16'hA5A5, frame_cnt_r, 8'h00, k_r};
        end else if (state_r == S_META) begin
            bcast_s[47:0] = {16'h5A5A, frame_cnt_r, counter_fs_r};
        end else begin
            bcast_s = {DW{1'b0}};
        end
    end

    // Steer streams: broadcast beats go to outputs not yet served, payload passes through
    always_comb begin
        axis_out1.tdata  = {DW{1'b0}};
        axis_out1.tvalid = 1'b0;
        axis_out2.tdata  = {DW{1'b0}};
        axis_out2.tvalid = 1'b0;
        axis_in.tready   = 1'b0;
        case (state_r)
            S_HEADER, S_META: begin
                axis_out1.tdata  = bcast_s;
                axis_out1.tvalid = ~taken1_r;
                axis_out2.tdata  = bcast_s;
                axis_out2.tvalid = ~taken2_r;
            end
            S_PAYLOAD: begin
                if (path_r) begin
                    axis_out1.tdata  = axis_in.tdata;
                    axis_out1.tvalid = axis_in.tvalid;
                    axis_in.tready   = axis_out1.tready;
                end else begin
                    axis_out2.tdata  = axis_in.tdata;
                    axis_out2.tvalid = axis_in.tvalid;
                    axis_in.tready   = axis_out2.tready;
                end
            end
            default: begin
                axis_in.tready = 1'b0;
            end
        endcase
    end

    assign hs1_s       = axis_out1.tvalid & axis_out1.tready;
    assign hs2_s       = axis_out2.tvalid & axis_out2.tready;
    assign in_hs_s     = axis_in.tvalid & axis_in.tready;
    // A broadcast beat is finished once each output has either taken it earlier or takes it now
    assign beat_done_s = (taken1_r | hs1_s) & (taken2_r | hs2_s);

    // Next-state logic for the frame FSM and its counters
    always_comb begin
        state_s      = state_r;
        k_s          = k_r;
        g_s          = g_r;
        taken1_s     = taken1_r;
        taken2_s     = taken2_r;
        path_s       = path_r;
        frame_cnt_s  = frame_cnt_r;
        counter_fs_s = counter_fs_r;
        case (state_r)
            S_IDLE: begin
                if (enable) begin
                    state_s      = S_HEADER;
                    k_s          = 8'd0;
                    g_s          = {GW{1'b0}};
                    taken1_s     = 1'b0;
                    taken2_s     = 1'b0;
                    path_s       = 1'b1;
                    counter_fs_s = 16'd0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_HEADER, S_META: begin
                if (beat_done_s) begin
                    taken1_s = 1'b0;
                    taken2_s = 1'b0;
                    if (state_r == S_HEADER && k_r == HDR_LAST) begin
                        state_s = S_PAYLOAD;
                        k_s     = 8'd0;
                    end else if (state_r == S_META && k_r == META_LAST) begin
                        state_s     = S_IDLE;
                        k_s         = 8'd0;
                        frame_cnt_s = frame_cnt_r + 16'd1;
                    end else begin
                        k_s = k_r + 8'd1;
                    end
                end else begin
                    taken1_s = taken1_r | hs1_s;
                    taken2_s = taken2_r | hs2_s;
                end
            end
            S_PAYLOAD: begin
                if (in_hs_s) begin
                    counter_fs_s = counter_fs_r + 16'd1;
                    if (g_r == G_LAST) begin
                        g_s    = {GW{1'b0}};
                        path_s = ~path_r;
                    end else begin
                        g_s = g_r + {{(GW-1){1'b0}}, 1'b1};
                    end
                    if (counter_fs_r == FS_LAST) begin
                        state_s = S_META;
                        k_s     = 8'd0;
                    end else begin
                        state_s = S_PAYLOAD;
                    end
                end else begin
                    state_s = S_PAYLOAD;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State and counter registers; reset abandons any frame in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_IDLE;
            k_r          <= 8'd0;
            g_r          <= {GW{1'b0}};
            taken1_r     <= 1'b0;
            taken2_r     <= 1'b0;
            path_r       <= 1'b1;
            frame_cnt_r  <= 16'd0;
            counter_fs_r <= 16'd0;
        end else begin
            state_r      <= state_s;
            k_r          <= k_s;
            g_r          <= g_s;
            taken1_r     <= taken1_s;
            taken2_r     <= taken2_s;
            path_r       <= path_s;
            frame_cnt_r  <= frame_cnt_s;
            counter_fs_r <= counter_fs_s;
        end
    end

endmodule

// File: tb/tb_pp_frame_sequencer.sv
// Self-checking bench for pp_frame_sequencer: per-output expected beat queues built from
// the frame format (headers, alternating payload groups, metadata) with random handshakes.
module tb_pp_frame_sequencer;

    localparam int DW  = 128;
    localparam int PPG = 2;
    localparam int PKS = 2;
    localparam int FS  = 8;
    localparam int HL  = 2;
    localparam int ML  = 2;
    localparam int G   = PPG * PKS;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        busy;
    logic        path;
    logic [15:0] frame_cnt;
    logic [15:0] counter_fs;

    pp_frame_sequencer_if #(.DW(DW)) axis_in ();
    pp_frame_sequencer_if #(.DW(DW)) axis_out1 ();
    pp_frame_sequencer_if #(.DW(DW)) axis_out2 ();

    pp_frame_sequencer #(
        .DW(DW), .PP_GROUP(PPG), .PACKET_SIZE(PKS),
        .FRAME_SIZE(FS), .HEADER_LEN(HL), .META_LEN(ML)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .busy       (busy),
        .path       (path),
        .frame_cnt  (frame_cnt),
        .counter_fs (counter_fs),
        .axis_in    (axis_in),
        .axis_out1  (axis_out1),
        .axis_out2  (axis_out2)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] q1[$];
    logic [DW-1:0] q2[$];
    bit            bq1[$];
    bit            bq2[$];
    logic [DW-1:0] pay[FS];
    int            pidx;
    int            b1;
    int            b2;
    logic [15:0]   fnum;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] hdr_word(input logic [15:0] f, input int k);
        logic [DW-1:0] w;
        w = '0;
        w[47:0] = {16'hA5A5, f, 16'(k)};
        return w;
    endfunction

    function automatic logic [DW-1:0] meta_word(input logic [15:0] f, input int n);
        logic [DW-1:0] w;
        w = '0;
        w[47:0] = {16'h5A5A, f, 16'(n)};
        return w;
    endfunction

    task automatic check_reset_vals();
        chk("rst_busy", DW'(busy), DW'(1'b0));
        chk("rst_path", DW'(path), DW'(1'b1));
        chk("rst_frame_cnt", DW'(frame_cnt), DW'(16'd0));
        chk("rst_counter_fs", DW'(counter_fs), DW'(16'd0));
        chk("rst_out1_valid", DW'(axis_out1.tvalid), DW'(1'b0));
        chk("rst_out2_valid", DW'(axis_out2.tvalid), DW'(1'b0));
        chk("rst_out1_data", axis_out1.tdata, DW'(1'b0));
        chk("rst_out2_data", axis_out2.tdata, DW'(1'b0));
        chk("rst_in_ready", DW'(axis_in.tready), DW'(1'b0));
    endtask

    // Expected content of each output for one frame, in order
    task automatic build_frame();
        q1.delete(); q2.delete(); bq1.delete(); bq2.delete();
        for (int k = 0; k < HL; k++) begin
            q1.push_back(hdr_word(fnum, k)); bq1.push_back(1'b1);
            q2.push_back(hdr_word(fnum, k)); bq2.push_back(1'b1);
        end
        for (int i = 0; i < FS; i++) begin
            pay[i] = {$urandom, $urandom, $urandom, $urandom};
            if (((i / G) % 2) == 0) begin
                q1.push_back(pay[i]); bq1.push_back(1'b0);
            end else begin
                q2.push_back(pay[i]); bq2.push_back(1'b0);
            end
        end
        for (int k = 0; k < ML; k++) begin
            q1.push_back(meta_word(fnum, FS)); bq1.push_back(1'b1);
            q2.push_back(meta_word(fnum, FS)); bq2.push_back(1'b1);
        end
        pidx = 0; b1 = 0; b2 = 0;
    endtask

    // mode 0: all ready/valid; 1: random; 2: out2 stalled 5 cycles in header;
    // 3: selected ready dropped 3 cycles mid-group; 6: enable dropped after first header beat
    task automatic run_frame(input int mode, input int abort_at);
        int  drop;
        int  st2;
        bit  done;
        bit  r1;
        bit  r2;
        bit  pay_ph;
        bit  sel1;
        drop = 0; st2 = 0; done = 1'b0;
        build_frame();
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            @(negedge clk);
            pay_ph = (b1 >= HL) && (b2 >= HL) && (pidx < FS);
            sel1   = (((pidx / G) % 2) == 0);
            r1 = 1'b1; r2 = 1'b1;
            axis_in.tvalid = 1'b1;
            if (mode == 1) begin
                r1 = 1'($urandom_range(0, 1));
                r2 = 1'($urandom_range(0, 1));
                axis_in.tvalid = 1'($urandom_range(0, 1));
            end
            if (mode == 2 && busy && b2 == 0 && st2 < 5) begin
                r2 = 1'b0; st2++;
            end
            if (mode == 3 && pay_ph && pidx == 2 && drop < 3) begin
                if (sel1) r1 = 1'b0; else r2 = 1'b0;
                drop++;
            end
            if (mode == 6 && (b1 > 0 || b2 > 0)) enable = 1'b0;
            axis_out1.tready = r1;
            axis_out2.tready = r2;
            axis_in.tdata = (pidx < FS) ? pay[pidx] : {$urandom, $urandom, $urandom, $urandom};
            if (abort_at >= 0 && pay_ph && pidx == abort_at) begin
                chk("pre_abort_cnt", DW'(counter_fs), DW'(pidx));
                reset = 1'b1;
                #1;
                check_reset_vals();
                reset = 1'b0;
                fnum = 16'd0;
                return;
            end
            #1;
            if (pay_ph) begin
                chk("path", DW'(path), DW'(sel1));
                chk("counter_fs", DW'(counter_fs), DW'(pidx));
                chk("in_tready", DW'(axis_in.tready), DW'(sel1 ? r1 : r2));
                chk("unsel_valid", DW'(sel1 ? axis_out2.tvalid : axis_out1.tvalid), DW'(1'b0));
                chk("sel_valid", DW'(sel1 ? axis_out1.tvalid : axis_out2.tvalid), DW'(axis_in.tvalid));
            end else begin
                chk("in_tready_bcast", DW'(axis_in.tready), DW'(1'b0));
                if (b1 > b2) chk("out1_no_dup", DW'(axis_out1.tvalid), DW'(1'b0));
                if (b2 > b1) chk("out2_no_dup", DW'(axis_out2.tvalid), DW'(1'b0));
            end
            if (axis_out1.tvalid && r1) begin
                if (q1.size() == 0) begin
                    chk("out1_extra", DW'(axis_out1.tvalid), DW'(1'b0));
                end else begin
                    chk("out1_data", axis_out1.tdata, q1[0]);
                    if (bq1[0]) b1++;
                    void'(q1.pop_front()); void'(bq1.pop_front());
                end
            end
            if (axis_out2.tvalid && r2) begin
                if (q2.size() == 0) begin
                    chk("out2_extra", DW'(axis_out2.tvalid), DW'(1'b0));
                end else begin
                    chk("out2_data", axis_out2.tdata, q2[0]);
                    if (bq2[0]) b2++;
                    void'(q2.pop_front()); void'(bq2.pop_front());
                end
            end
            if (pay_ph && axis_in.tvalid && (sel1 ? r1 : r2)) pidx++;
            done = (q1.size() == 0) && (q2.size() == 0);
            @(posedge clk);
        end
        chk("frame_done", DW'(done), DW'(1'b1));
        #1;
        chk("end_busy", DW'(busy), DW'(1'b0));
        chk("end_frame_cnt", DW'(frame_cnt), DW'(fnum + 16'd1));
        chk("end_counter_fs", DW'(counter_fs), DW'(FS));
        fnum = fnum + 16'd1;
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        axis_in.tvalid = 1'b0;
        axis_in.tdata = '0;
        axis_out1.tready = 1'b0;
        axis_out2.tready = 1'b0;
        fnum = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b1;

        // Full-rate frame, then exactly one idle cycle before the next header
        run_frame(0, -1);
        @(posedge clk);
        #1;
        chk("idle_gap_then_header", DW'(busy), DW'(1'b1));

        // Header back-pressure on out2
        run_frame(2, -1);
        // Selected ready dropped mid-group
        run_frame(3, -1);
        // Random valid/ready traffic
        for (int f = 0; f < 6; f++) run_frame(1, -1);

        // Reset in the middle of the payload, then a clean restart from frame 0
        run_frame(0, 5);
        run_frame(0, -1);

        // Enable removed during a frame: frame finishes, then the FSM stays idle
        run_frame(6, -1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_hold_busy", DW'(busy), DW'(1'b0));
            chk("idle_hold_cnt", DW'(frame_cnt), DW'(fnum));
        end
        enable = 1'b1;
        run_frame(1, -1);
        run_frame(0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
